// File: rtl/fill_ctrl_pkg.sv
// fill_ctrl_pkg
// Shared encodings for the pill-bottling controller.
//   state_e : SETTING / RUNNING / PAUSED / DONE, as seen on state_o
//   fault_e : pause cause, as seen on fault_o
//   bcd_digit_inc : one BCD digit plus one, returns {carry, digit}
package fill_ctrl_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        ST_SETTING = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        FLT_NONE     = 3'd0,
        FLT_ESTOP    = 3'd1,
        FLT_HOPPER   = 3'd2,
        FLT_CONVEYOR = 3'd3,
        FLT_STALL    = 3'd4
    } fault_e;

    // Codes 9..15 all roll over to 0 with carry, so a corrupted digit heals.
    function automatic logic [BCD_W:0] bcd_digit_inc(input logic [BCD_W-1:0] d);
        logic [BCD_W:0] r;
        if (d >= 4'd9) begin
            r = {1'b1, 4'd0};
        end else begin
            r = {1'b0, d + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_counter_n.sv
// bcd_counter_n
// N-digit ripple-carry BCD counter with synchronous clear.
//   clk   : clock
//   clr   : synchronous clear, wins over inc
//   inc   : add one at the next edge
//   q     : registered count, digit0 in the LSBs
//   q_inc : combinational value of q+1 (lets the parent compare before committing)
module bcd_counter_n
    import fill_ctrl_pkg::*;
#(
    parameter int DIGITS = 3
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      inc,
    output logic [BCD_W*DIGITS-1:0]   q,
    output logic [BCD_W*DIGITS-1:0]   q_inc
);

    logic [BCD_W*DIGITS-1:0] cnt_q;
    logic [BCD_W*DIGITS-1:0] cnt_d;
    logic [BCD_W*DIGITS-1:0] inc_val_s;
    logic [BCD_W:0]          dig_s;
    logic                    carry_s;

    // Ripple the carry digit by digit to form count + 1.
    always_comb begin
        inc_val_s = cnt_q;
        carry_s   = 1'b1;
        dig_s     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry_s) begin
                dig_s                    = bcd_digit_inc(cnt_q[BCD_W*i +: BCD_W]);
                inc_val_s[BCD_W*i +: BCD_W] = dig_s[BCD_W-1:0];
                carry_s                  = dig_s[BCD_W];
            end else begin
                inc_val_s[BCD_W*i +: BCD_W] = cnt_q[BCD_W*i +: BCD_W];
            end
        end
    end

    // Next count select.
    always_comb begin
        if (inc) begin
            cnt_d = inc_val_s;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q     = cnt_q;
    assign q_inc = inc_val_s;

endmodule

// File: rtl/bottle_fill_ctrl_p.sv
// bottle_fill_ctrl_p
// Pill-bottling controller: operator edits BCD targets with pos/inc keys,
// start runs the fill, pill pulses fill bottles, bottles fill a batch.
// External faults and a no-pill watchdog pause the run; start resumes.
//   clk_1khz, switch_clr          : clock, synchronous active-high reset
//   key_pos/key_inc/key_start     : operator keys (rising edge = event)
//   estop/hopper_empty/conveyor_stop : fault levels
//   pill_in                       : pill sensor (rising edge = one pill)
//   state_o, fault_o, position_o  : FSM state, pause cause, selected digit
//   tgt_pills_o, tgt_bottles_o    : BCD targets
//   pills_o, bottles_o            : BCD progress counts
//   beep_o                        : 2 Hz beeper while DONE
module bottle_fill_ctrl_p
    import fill_ctrl_pkg::*;
#(
    parameter int PILL_DIGITS   = 3,
    parameter int BOTTLE_DIGITS = 2,
    parameter int TICKS_PER_SEC = 1000,
    parameter int STALL_SECS    = 5
) (
    input  logic                           clk_1khz,
    input  logic                           switch_clr,
    input  logic                           key_pos,
    input  logic                           key_inc,
    input  logic                           key_start,
    input  logic                           estop,
    input  logic                           hopper_empty,
    input  logic                           conveyor_stop,
    input  logic                           pill_in,
    output logic [1:0]                     state_o,
    output logic [2:0]                     fault_o,
    output logic [2:0]                     position_o,
    output logic [BCD_W*PILL_DIGITS-1:0]   tgt_pills_o,
    output logic [BCD_W*BOTTLE_DIGITS-1:0] tgt_bottles_o,
    output logic [BCD_W*PILL_DIGITS-1:0]   pills_o,
    output logic [BCD_W*BOTTLE_DIGITS-1:0] bottles_o,
    output logic                           beep_o
);

    localparam int TOTAL_DIGITS = PILL_DIGITS + BOTTLE_DIGITS;
    localparam int PILL_W       = BCD_W * PILL_DIGITS;
    localparam int TGT_W        = BCD_W * TOTAL_DIGITS;
    localparam int WD_LIMIT     = STALL_SECS * TICKS_PER_SEC;
    localparam int WD_W         = $clog2(WD_LIMIT + 1);
    localparam int BEEP_HALF    = TICKS_PER_SEC / 4;
    localparam int BEEP_W       = $clog2(BEEP_HALF + 1);

    localparam logic [2:0]        POS_LAST  = 3'(TOTAL_DIGITS - 1);
    localparam logic [WD_W-1:0]   WD_ONE    = WD_W'(1);
    localparam logic [WD_W-1:0]   WD_MAX    = WD_W'(WD_LIMIT);
    localparam logic [BEEP_W-1:0] BEEP_ONE  = BEEP_W'(1);
    localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_HALF - 1);
    // Both targets reset to 1 (digit0 of each field).
    localparam logic [TGT_W-1:0]  TGT_RST   = TGT_W'(1) | (TGT_W'(1) << PILL_W);

    state_e              state_q, state_d;
    fault_e              fault_q, fault_d, fault_code_s;
    logic [2:0]          position_q, position_d;
    logic [TGT_W-1:0]    tgt_q, tgt_d;
    logic [WD_W-1:0]     wd_q, wd_d, wd_inc_s;
    logic [BEEP_W-1:0]   beep_cnt_q, beep_cnt_d;
    logic                beep_q, beep_d;
    logic                key_pos_q, key_inc_q, key_start_q, pill_q;
    logic                pos_rise_s, inc_rise_s, start_rise_s, pill_rise_s;
    logic                fault_any_s, targets_ok_s;
    logic                clear_counts_s, pill_inc_s, bottle_done_s;
    logic                pill_clr_s, bottle_clr_s;
    logic [BCD_W:0]      digit_inc_s;
    logic [PILL_W-1:0]               tgt_pills_s, pills_s, pills_inc_s;
    logic [TGT_W-PILL_W-1:0]         tgt_bottles_s, bottles_s, bottles_inc_s;

    assign tgt_pills_s   = tgt_q[PILL_W-1:0];
    assign tgt_bottles_s = tgt_q[TGT_W-1:PILL_W];
    assign pos_rise_s    = key_pos & ~key_pos_q;
    assign inc_rise_s    = key_inc & ~key_inc_q;
    assign start_rise_s  = key_start & ~key_start_q;
    assign pill_rise_s   = pill_in & ~pill_q;
    assign fault_any_s   = estop | hopper_empty | conveyor_stop;
    // BCD zero is all-zero bits, so a plain OR-reduce detects it.
    assign targets_ok_s  = (|tgt_pills_s) & (|tgt_bottles_s);
    assign wd_inc_s      = wd_q + WD_ONE;
    assign pill_clr_s    = switch_clr | clear_counts_s | bottle_done_s;
    assign bottle_clr_s  = switch_clr | clear_counts_s;

    // Pause cause priority: estop over hopper over conveyor.
    always_comb begin
        if (estop) begin
            fault_code_s = FLT_ESTOP;
        end else if (hopper_empty) begin
            fault_code_s = FLT_HOPPER;
        end else if (conveyor_stop) begin
            fault_code_s = FLT_CONVEYOR;
        end else begin
            fault_code_s = FLT_NONE;
        end
    end

    // FSM next state, target editing, watchdog and counter controls.
    always_comb begin
        state_d        = state_q;
        fault_d        = fault_q;
        position_d     = position_q;
        tgt_d          = tgt_q;
        wd_d           = wd_q;
        clear_counts_s = 1'b0;
        pill_inc_s     = 1'b0;
        bottle_done_s  = 1'b0;
        digit_inc_s    = '0;
        case (state_q)
            ST_SETTING: begin
                if (pos_rise_s) begin
                    if (position_q == POS_LAST) begin
                        position_d = 3'd0;
                    end else begin
                        position_d = position_q + 3'd1;
                    end
                end else begin
                    position_d = position_q;
                end
                // Edit uses the old position when pos and inc rise together.
                for (int i = 0; i < TOTAL_DIGITS; i++) begin
                    if (inc_rise_s && (position_q == 3'(i))) begin
                        digit_inc_s              = bcd_digit_inc(tgt_q[BCD_W*i +: BCD_W]);
                        tgt_d[BCD_W*i +: BCD_W] = digit_inc_s[BCD_W-1:0];
                    end else begin
                        tgt_d[BCD_W*i +: BCD_W] = tgt_q[BCD_W*i +: BCD_W];
                    end
                end
                if (start_rise_s && targets_ok_s) begin
                    state_d        = ST_RUNNING;
                    fault_d        = FLT_NONE;
                    clear_counts_s = 1'b1;
                    wd_d           = '0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUNNING: begin
                if (fault_any_s) begin
                    // A pill arriving in the same cycle is deliberately lost.
                    state_d = ST_PAUSED;
                    fault_d = fault_code_s;
                end else if (pill_rise_s) begin
                    wd_d = '0;
                    if (pills_inc_s == tgt_pills_s) begin
                        bottle_done_s = 1'b1;
                        if (bottles_inc_s == tgt_bottles_s) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = state_q;
                        end
                    end else begin
                        pill_inc_s = 1'b1;
                    end
                end else if (wd_inc_s == WD_MAX) begin
                    state_d = ST_PAUSED;
                    fault_d = FLT_STALL;
                    wd_d    = '0;
                end else begin
                    wd_d = wd_inc_s;
                end
            end
            ST_PAUSED: begin
                if (start_rise_s && !fault_any_s) begin
                    state_d = ST_RUNNING;
                    fault_d = FLT_NONE;
                    wd_d    = '0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_DONE: begin
                if (start_rise_s) begin
                    state_d        = ST_RUNNING;
                    fault_d        = FLT_NONE;
                    clear_counts_s = 1'b1;
                    wd_d           = '0;
                end else if (pos_rise_s) begin
                    state_d    = ST_SETTING;
                    position_d = 3'd0;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_SETTING;
                fault_d = FLT_NONE;
            end
        endcase
    end

    // Beeper: restart high on DONE entry, toggle every BEEP_HALF cycles.
    always_comb begin
        beep_d     = 1'b0;
        beep_cnt_d = '0;
        if (state_d == ST_DONE) begin
            if (state_q != ST_DONE) begin
                beep_d     = 1'b1;
                beep_cnt_d = '0;
            end else if (beep_cnt_q == BEEP_LAST) begin
                beep_d     = ~beep_q;
                beep_cnt_d = '0;
            end else begin
                beep_d     = beep_q;
                beep_cnt_d = beep_cnt_q + BEEP_ONE;
            end
        end else begin
            beep_d     = 1'b0;
            beep_cnt_d = '0;
        end
    end

    // Input history for rising-edge detection.
    always_ff @(posedge clk_1khz) begin
        if (switch_clr) begin
            key_pos_q   <= 1'b0;
            key_inc_q   <= 1'b0;
            key_start_q <= 1'b0;
            pill_q      <= 1'b0;
        end else begin
            key_pos_q   <= key_pos;
            key_inc_q   <= key_inc;
            key_start_q <= key_start;
            pill_q      <= pill_in;
        end
    end

    // Control state registers.
    always_ff @(posedge clk_1khz) begin
        if (switch_clr) begin
            state_q    <= ST_SETTING;
            fault_q    <= FLT_NONE;
            position_q <= 3'd0;
            tgt_q      <= TGT_RST;
            wd_q       <= '0;
            beep_q     <= 1'b0;
            beep_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fault_q    <= fault_d;
            position_q <= position_d;
            tgt_q      <= tgt_d;
            wd_q       <= wd_d;
            beep_q     <= beep_d;
            beep_cnt_q <= beep_cnt_d;
        end
    end

    bcd_counter_n #(.DIGITS(PILL_DIGITS)) u_pill_cnt (
        .clk   (clk_1khz),
        .clr   (pill_clr_s),
        .inc   (pill_inc_s),
        .q     (pills_s),
        .q_inc (pills_inc_s)
    );

    bcd_counter_n #(.DIGITS(BOTTLE_DIGITS)) u_bottle_cnt (
        .clk   (clk_1khz),
        .clr   (bottle_clr_s),
        .inc   (bottle_done_s),
        .q     (bottles_s),
        .q_inc (bottles_inc_s)
    );

    assign state_o       = state_q;
    assign fault_o       = fault_q;
    assign position_o    = position_q;
    assign tgt_pills_o   = tgt_pills_s;
    assign tgt_bottles_o = tgt_bottles_s;
    assign pills_o       = pills_s;
    assign bottles_o     = bottles_s;
    assign beep_o        = beep_q;

endmodule
